// File: rtl/lamp_seq_pkg.sv
// Shared definitions for the lamp sequencer: the state encoding that is also
// presented on the phase output, and small helpers that classify states.
package lamp_seq_pkg;

    localparam int PHASE_W = 3;

    // State encoding doubles as the external phase value.
    // Value 7 is not a legal state and is steered back to IDLE.
    typedef enum logic [PHASE_W-1:0] {
        S_IDLE = 3'd0,
        S_UP1  = 3'd1,
        S_DN1  = 3'd2,
        S_UP2  = 3'd3,
        S_DN2  = 3'd4,
        S_UP3  = 3'd5,
        S_DN3  = 3'd6
    } lamp_state_e;

    // True for states in which each step lights one more lamp.
    function automatic logic is_up_state(lamp_state_e s);
        return (s == S_UP1) || (s == S_UP2) || (s == S_UP3);
    endfunction

    // True for states in which each step turns one lamp off.
    function automatic logic is_dn_state(lamp_state_e s);
        return (s == S_DN1) || (s == S_DN2) || (s == S_DN3);
    endfunction

endpackage

// File: rtl/lamp_sequencer_step_tick.sv
// Step prescaler: produces a one-cycle tick every STEP_DIV cycles while clr
// is low. Holding clr high parks the count at zero, so the first tick after
// clr drops lands exactly STEP_DIV cycles later.
module step_tick #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] pcnt;

    if (STEP_DIV < 1) begin : g_bad_div
        $fatal(1, "step_tick: STEP_DIV must be at least 1");
    end

    // Tick is suppressed while cleared so an idle sequencer never steps.
    assign tick = !clr && (pcnt == LAST);

    // Count cycles within the current step period, wrapping on each tick.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + ONE;
        end
    end

endmodule

// File: rtl/lamp_sequencer.sv
// Lamp sequencer: drives a thermometer-coded lamp bar through the pattern
// up to MID_A, down to 0, up to MID_B, down to MID_A, up to N_LAMPS and back
// down to 0, one lamp per step. A flick in IDLE starts the sequence.
// Optional feature macro: LAMP_SEQ_KICKBACK_EN lets a flick on selected
// steps of UP2/UP3 throw the sequence back to an earlier descent.
module lamp_sequencer
    import lamp_seq_pkg::*;
#(
    parameter int N_LAMPS  = 16,
    parameter int MID_A    = 5,
    parameter int MID_B    = 10,
    parameter int STEP_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flick,
    output logic [N_LAMPS-1:0] lamp,
    output logic               busy,
    output logic [2:0]         phase
);

    localparam int CW = $clog2(N_LAMPS + 1);
    localparam logic [CW-1:0] CNT_A   = CW'(MID_A);
    localparam logic [CW-1:0] CNT_B   = CW'(MID_B);
    localparam logic [CW-1:0] CNT_TOP = CW'(N_LAMPS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    lamp_state_e   state;
    lamp_state_e   state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          restart;
    logic          restart_next;
    logic          tick;
    logic          tick_clr;

    if (N_LAMPS < 3) begin : g_bad_n
        $fatal(1, "lamp_sequencer: N_LAMPS must be at least 3");
    end
    if (!(MID_A > 0 && MID_A < MID_B)) begin : g_bad_a
        $fatal(1, "lamp_sequencer: need 0 < MID_A < MID_B");
    end
    if (MID_B >= N_LAMPS) begin : g_bad_b
        $fatal(1, "lamp_sequencer: need MID_B < N_LAMPS");
    end
    if (STEP_DIV < 1) begin : g_bad_div
        $fatal(1, "lamp_sequencer: STEP_DIV must be at least 1");
    end

    // The prescaler only runs while a sequence is in progress, which also
    // restarts its period on every entry into UP1.
    assign tick_clr = (state == S_IDLE);

    step_tick #(
        .STEP_DIV (STEP_DIV)
    ) u_step_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            restart <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            restart <= restart_next;
        end
    end

    // Step the count on ticks and pick the next state from the updated count.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        restart_next = 1'b0;

        if (tick && is_up_state(state)) begin
            cnt_next = cnt + CNT_ONE;
        end else if (tick && is_dn_state(state)) begin
            cnt_next = cnt - CNT_ONE;
        end

        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (flick || restart) begin
                    state_next = S_UP1;
                end
            end
            S_UP1: begin
                if (tick && cnt_next == CNT_A) begin
                    state_next = S_DN1;
                end
            end
            S_DN1: begin
                if (tick && cnt_next == '0) begin
                    state_next = S_UP2;
                end
            end
            S_UP2: begin
                if (tick && cnt_next == CNT_B) begin
                    state_next = S_DN2;
                end
`ifdef LAMP_SEQ_KICKBACK_EN
                if (tick && flick && (cnt_next == CNT_A || cnt_next == CNT_B)) begin
                    state_next = S_DN1;
                end
`endif
            end
            S_DN2: begin
                if (tick && cnt_next == CNT_A) begin
                    state_next = S_UP3;
                end
            end
            S_UP3: begin
                if (tick && cnt_next == CNT_TOP) begin
                    state_next = S_DN3;
                end
`ifdef LAMP_SEQ_KICKBACK_EN
                if (tick && flick && cnt_next == CNT_B) begin
                    state_next = S_DN2;
                end
`endif
            end
            S_DN3: begin
                if (tick && cnt_next == '0) begin
                    state_next   = S_IDLE;
                    restart_next = flick;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Thermometer decode: the low cnt bits are lit.
    always_comb begin
        lamp = ~({N_LAMPS{1'b1}} << cnt);
    end

    assign busy  = (state != S_IDLE);
    assign phase = state;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Scoreboard bench for lamp_sequencer. Two instances share the same stimulus:
// the default configuration and a small, slow one (8 lamps, STEP_DIV=4).
// A step-rule model predicts every cycle's outputs; a monitor compares.
module tb_lamp_sequencer;

    typedef struct {
        int ph;
        int cnt;
        int pre;
        bit restart;
    } mdl_t;

    typedef struct {
        logic [15:0] lamp;
        logic        busy;
        logic [2:0]  phase;
    } exp_t;

`ifdef LAMP_SEQ_KICKBACK_EN
    localparam bit KB = 1'b1;
`else
    localparam bit KB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flick;
    logic [15:0] lamp0;
    logic        busy0;
    logic [2:0]  phase0;
    logic [7:0]  lamp1;
    logic        busy1;
    logic [2:0]  phase1;

    int   checks;
    int   failures;
    mdl_t m0;
    mdl_t m1;
    exp_t q0[$];
    exp_t q1[$];

    lamp_sequencer dut0 (
        .clk   (clk),
        .rst   (rst),
        .flick (flick),
        .lamp  (lamp0),
        .busy  (busy0),
        .phase (phase0)
    );

    lamp_sequencer #(
        .N_LAMPS  (8),
        .MID_A    (2),
        .MID_B    (5),
        .STEP_DIV (4)
    ) dut1 (
        .clk   (clk),
        .rst   (rst),
        .flick (flick),
        .lamp  (lamp1),
        .busy  (busy1),
        .phase (phase1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge of the sequence rules: targets per phase, odd phases
    // climb, even phases descend, steps happen every div edges.
    function automatic mdl_t model_step(mdl_t m, bit r, bit f, int n, int a, int b, int div);
        mdl_t x;
        int   tgt[7];
        x = m;
        tgt = '{0, a, 0, b, a, n, 0};
        x.restart = 1'b0;
        if (r) begin
            x.ph = 0; x.cnt = 0; x.pre = 0;
            return x;
        end
        if (m.ph == 0) begin
            x.pre = 0; x.cnt = 0;
            if (f || m.restart) x.ph = 1;
            return x;
        end
        x.pre = m.pre + 1;
        if (x.pre < div) return x;
        x.pre = 0;
        x.cnt = m.cnt + ((m.ph % 2 == 1) ? 1 : -1);
        if (x.cnt == tgt[m.ph]) begin
            if (m.ph == 6) begin
                x.ph = 0;
                x.restart = f;
            end else begin
                x.ph = m.ph + 1;
            end
        end
        if (KB && f && m.ph == 3 && (x.cnt == a || x.cnt == b)) x.ph = 2;
        if (KB && f && m.ph == 5 && x.cnt == b) x.ph = 4;
        return x;
    endfunction

    function automatic exp_t to_exp(mdl_t m);
        exp_t e;
        e.lamp = '0;
        for (int i = 0; i < m.cnt; i++) e.lamp[i] = 1'b1;
        e.busy  = (m.ph != 0);
        e.phase = 3'(m.ph);
        return e;
    endfunction

    // Drive one cycle of inputs, then record what both models expect after the edge.
    task automatic applyStimulus(input bit r, input bit f);
        rst   = r;
        flick = f;
        @(posedge clk);
        #1;
        m0 = model_step(m0, r, f, 16, 5, 10, 1);
        m1 = model_step(m1, r, f, 8, 2, 5, 4);
        q0.push_back(to_exp(m0));
        q1.push_back(to_exp(m1));
    endtask

    task automatic checkOutput(input string name, input exp_t e,
                               input logic [15:0] l, input logic b, input logic [2:0] p);
        checks++;
        if (l !== e.lamp) begin
            failures++;
            $display("[TB] FAIL %s lamp got=%h want=%h at %0t", name, l, e.lamp, $time);
        end
        checks++;
        if (b !== e.busy) begin
            failures++;
            $display("[TB] FAIL %s busy got=%b want=%b at %0t", name, b, e.busy, $time);
        end
        checks++;
        if (p !== e.phase) begin
            failures++;
            $display("[TB] FAIL %s phase got=%0d want=%0d at %0t", name, p, e.phase, $time);
        end
    endtask

    // Idle the inputs until the default-config model reaches a given point.
    task automatic waitModel0(input int ph, input int cnt, input int budget);
        int n;
        n = 0;
        while (!(m0.ph == ph && m0.cnt == cnt) && n < budget) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checks++;
        if (!(m0.ph == ph && m0.cnt == cnt)) begin
            failures++;
            $display("[TB] FAIL wait_ph%0d_cnt%0d got=ph%0d/cnt%0d want=reached within %0d cycles",
                     ph, cnt, m0.ph, m0.cnt, budget);
        end
    endtask

    // Monitor: every cycle the outputs are present, so pop and compare.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checkOutput("dut0", e, lamp0, busy0, phase0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput("dut1", e, {8'h00, lamp1}, busy1, phase1);
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        m0 = '{0, 0, 0, 1'b0};
        m1 = '{0, 0, 0, 1'b0};
        rst   = 1'b1;
        flick = 1'b0;

        $display("[TB] reset");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

        $display("[TB] single flick pulse, full nominal trace");
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 130; i++) applyStimulus(1'b0, 1'b0);

        $display("[TB] reset mid UP3 with flick high");
        applyStimulus(1'b0, 1'b1);
        waitModel0(5, 12, 100);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);

`ifdef LAMP_SEQ_KICKBACK_EN
        $display("[TB] kickback from UP2 at 10");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        waitModel0(3, 9, 100);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);

        $display("[TB] kickback from UP3 at 10");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        waitModel0(5, 9, 100);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);
`endif

        $display("[TB] flick held high, back-to-back sequences");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 260; i++) applyStimulus(1'b0, 1'b1);

        $display("[TB] randomized flick and reset");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0));
        end

        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (q0.size() + q1.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain got=%0d pending want=0", q0.size() + q1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
